// File: rtl/alu16_registered.sv
// alu16_registered: 16-function unsigned ALU with a registered result and
// one-hot function-class flags. Everything is combinational from A, B and
// ALU_FUN and is captured on every rising clk edge, so latency is one cycle.
// A new operation is accepted every cycle.
//
// Ports:
//   clk        - system clock, rising-edge active
//   rst        - synchronous reset, active-high; clears ALU_OUT and flags
//   A, B       - unsigned operands
//   ALU_FUN    - 4-bit function select
//   ALU_OUT    - registered result
//   Arith_Flag - registered; captured opcode was ADD/SUB/MUL/DIV
//   Logic_Flag - registered; captured opcode was AND..XNOR
//   CMP_Flag   - registered; captured opcode was EQ/GT/LT
//   Shift_Flag - registered; captured opcode was SHR/SHL (or ROL)
//
// Build option:
//   ALU_ROTATE_EN - when defined, opcode 1111 rotates A left by one and
//                   raises Shift_Flag; otherwise 1111 yields zero and no flags.
module alu16_registered #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             Arith_Flag,
    output logic             Logic_Flag,
    output logic             CMP_Flag,
    output logic             Shift_Flag
);

    typedef enum logic [3:0] {
        OpAdd  = 4'b0000,
        OpSub  = 4'b0001,
        OpMul  = 4'b0010,
        OpDiv  = 4'b0011,
        OpAnd  = 4'b0100,
        OpOr   = 4'b0101,
        OpNand = 4'b0110,
        OpNor  = 4'b0111,
        OpXor  = 4'b1000,
        OpXnor = 4'b1001,
        OpEq   = 4'b1010,
        OpGt   = 4'b1011,
        OpLt   = 4'b1100,
        OpShr  = 4'b1101,
        OpShl  = 4'b1110,
        OpRol  = 4'b1111
    } alu_op_e;

    alu_op_e          op;
    logic [WIDTH-1:0] result_d;
    logic             arith_d;
    logic             logic_d;
    logic             cmp_d;
    logic             shift_d;

    assign op = alu_op_e'(ALU_FUN);

    always_comb begin
        result_d = '0;
        arith_d  = 1'b0;
        logic_d  = 1'b0;
        cmp_d    = 1'b0;
        shift_d  = 1'b0;
        unique case (op)
            OpAdd: begin
                result_d = A + B;
                arith_d  = 1'b1;
            end
            OpSub: begin
                result_d = A - B;
                arith_d  = 1'b1;
            end
            OpMul: begin
                // Assignment context truncates the product to its low WIDTH bits.
                result_d = A * B;
                arith_d  = 1'b1;
            end
            OpDiv: begin
                // Divide by zero is defined as zero rather than left to the tool.
                result_d = (B == '0) ? '0 : A / B;
                arith_d  = 1'b1;
            end
            OpAnd: begin
                result_d = A & B;
                logic_d  = 1'b1;
            end
            OpOr: begin
                result_d = A | B;
                logic_d  = 1'b1;
            end
            OpNand: begin
                result_d = ~(A & B);
                logic_d  = 1'b1;
            end
            OpNor: begin
                result_d = ~(A | B);
                logic_d  = 1'b1;
            end
            OpXor: begin
                result_d = A ^ B;
                logic_d  = 1'b1;
            end
            OpXnor: begin
                result_d = ~(A ^ B);
                logic_d  = 1'b1;
            end
            // Compare codes are distinct per test so a consumer can tell them apart.
            OpEq: begin
                result_d = (A == B) ? WIDTH'(1) : '0;
                cmp_d    = 1'b1;
            end
            OpGt: begin
                result_d = (A > B) ? WIDTH'(2) : '0;
                cmp_d    = 1'b1;
            end
            OpLt: begin
                result_d = (A < B) ? WIDTH'(3) : '0;
                cmp_d    = 1'b1;
            end
            OpShr: begin
                result_d = A >> 1;
                shift_d  = 1'b1;
            end
            OpShl: begin
                result_d = A << 1;
                shift_d  = 1'b1;
            end
            OpRol: begin
`ifdef ALU_ROTATE_EN
                result_d = {A[WIDTH-2:0], A[WIDTH-1]};
                shift_d  = 1'b1;
`else
                result_d = '0;
`endif
            end
            default: begin
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_OUT    <= '0;
            Arith_Flag <= 1'b0;
            Logic_Flag <= 1'b0;
            CMP_Flag   <= 1'b0;
            Shift_Flag <= 1'b0;
        end else begin
            ALU_OUT    <= result_d;
            Arith_Flag <= arith_d;
            Logic_Flag <= logic_d;
            CMP_Flag   <= cmp_d;
            Shift_Flag <= shift_d;
        end
    end

endmodule

// File: tb/tb_alu16_registered.sv
// Self-checking bench for alu16_registered. Directed vectors live in a table;
// each applied vector pushes its expected result into a scoreboard queue that
// is popped and compared one cycle later, after the capturing edge.
module tb_alu16_registered;

    localparam logic [3:0] FL_NONE  = 4'b0000;
    localparam logic [3:0] FL_ARITH = 4'b1000;
    localparam logic [3:0] FL_LOGIC = 4'b0100;
    localparam logic [3:0] FL_CMP   = 4'b0010;
    localparam logic [3:0] FL_SHIFT = 4'b0001;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    logic [15:0] alu_out;
    logic        arith_flag;
    logic        logic_flag;
    logic        cmp_flag;
    logic        shift_flag;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
        logic [15:0] out;
        logic [3:0]  flg;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic [3:0]  flg;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    alu16_registered #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (a),
        .B          (b),
        .ALU_FUN    (fun),
        .ALU_OUT    (alu_out),
        .Arith_Flag (arith_flag),
        .Logic_Flag (logic_flag),
        .CMP_Flag   (cmp_flag),
        .Shift_Flag (shift_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector, push its expectation, then check after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        logic [3:0] flags;
        rst = v.rst;
        a   = v.a;
        b   = v.b;
        fun = v.fun;
        e.out  = v.out;
        e.flg  = v.flg;
        e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got   = sb.pop_front();
        flags = {arith_flag, logic_flag, cmp_flag, shift_flag};
        compared++;
        if (alu_out !== got.out || flags !== got.flg) begin
            mismatched++;
            $display("FAIL %s: got out=%h flags=%b, expected out=%h flags=%b",
                     got.name, alu_out, flags, got.out, got.flg);
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        fun = '0;

        // Reset held for two edges, then first result one edge after release.
        vecs.push_back('{1'b1, 16'd15, 16'd10, 4'b0000, 16'h0000, FL_NONE,  "reset_edge1"});
        vecs.push_back('{1'b1, 16'd15, 16'd10, 4'b0000, 16'h0000, FL_NONE,  "reset_edge2"});
        vecs.push_back('{1'b0, 16'd15, 16'd10, 4'b0000, 16'd25,   FL_ARITH, "post_reset_add"});
        // Arithmetic
        vecs.push_back('{1'b0, 16'd15, 16'd10, 4'b0001, 16'd5,    FL_ARITH, "sub"});
        vecs.push_back('{1'b0, 16'd15, 16'd10, 4'b0010, 16'd150,  FL_ARITH, "mul"});
        vecs.push_back('{1'b0, 16'd15, 16'd10, 4'b0011, 16'd1,    FL_ARITH, "div"});
        vecs.push_back('{1'b0, 16'd15, 16'd0,  4'b0011, 16'd0,    FL_ARITH, "div_by_zero"});
        vecs.push_back('{1'b0, 16'd5,  16'd10, 4'b0001, 16'hFFFB, FL_ARITH, "sub_wrap"});
        vecs.push_back('{1'b0, 16'hFFFF, 16'h0002, 4'b0000, 16'h0001, FL_ARITH, "add_carry_drop"});
        vecs.push_back('{1'b0, 16'h1234, 16'h0100, 4'b0010, 16'h3400, FL_ARITH, "mul_trunc"});
        vecs.push_back('{1'b0, 16'd100, 16'd7, 4'b0011, 16'd14,   FL_ARITH, "div_floor"});
        // Logic
        vecs.push_back('{1'b0, 16'h0015, 16'h000A, 4'b0100, 16'h0000, FL_LOGIC, "and"});
        vecs.push_back('{1'b0, 16'h0015, 16'h000A, 4'b0101, 16'h001F, FL_LOGIC, "or"});
        vecs.push_back('{1'b0, 16'h0015, 16'h000A, 4'b0110, 16'hFFFF, FL_LOGIC, "nand"});
        vecs.push_back('{1'b0, 16'h0015, 16'h000A, 4'b1000, 16'h001F, FL_LOGIC, "xor"});
        vecs.push_back('{1'b0, 16'h0005, 16'h000A, 4'b0111, 16'hFFF0, FL_LOGIC, "nor"});
        vecs.push_back('{1'b0, 16'h0005, 16'h000A, 4'b1001, 16'hFFF0, FL_LOGIC, "xnor"});
        vecs.push_back('{1'b0, 16'h00F0, 16'h0FF0, 4'b0100, 16'h00F0, FL_LOGIC, "and_nonzero"});
        // Compare
        vecs.push_back('{1'b0, 16'h0015, 16'h0015, 4'b1010, 16'd1, FL_CMP, "eq_true"});
        vecs.push_back('{1'b0, 16'h0015, 16'h0016, 4'b1010, 16'd0, FL_CMP, "eq_false"});
        vecs.push_back('{1'b0, 16'h001D, 16'h0015, 4'b1011, 16'd2, FL_CMP, "gt_true"});
        vecs.push_back('{1'b0, 16'h0015, 16'h001D, 4'b1100, 16'd3, FL_CMP, "lt_true"});
        vecs.push_back('{1'b0, 16'h0015, 16'h001D, 4'b1011, 16'd0, FL_CMP, "gt_false"});
        vecs.push_back('{1'b0, 16'h001D, 16'h0015, 4'b1100, 16'd0, FL_CMP, "lt_false"});
        vecs.push_back('{1'b0, 16'h8000, 16'h7FFF, 4'b1011, 16'd2, FL_CMP, "gt_unsigned"});
        // Shift
        vecs.push_back('{1'b0, 16'h0013, 16'hFFFF, 4'b1101, 16'h0009, FL_SHIFT, "shr"});
        vecs.push_back('{1'b0, 16'h0013, 16'h1234, 4'b1110, 16'h0026, FL_SHIFT, "shl"});
        vecs.push_back('{1'b0, 16'h8001, 16'h0000, 4'b1110, 16'h0002, FL_SHIFT, "shl_msb_drop"});
        vecs.push_back('{1'b0, 16'h8001, 16'h0000, 4'b1101, 16'h4000, FL_SHIFT, "shr_zero_fill"});
        // Opcode 1111
`ifdef ALU_ROTATE_EN
        vecs.push_back('{1'b0, 16'h8001, 16'h0000, 4'b1111, 16'h0003, FL_SHIFT, "rol"});
`else
        vecs.push_back('{1'b0, 16'h8001, 16'h0000, 4'b1111, 16'h0000, FL_NONE,  "op1111_off"});
`endif
        // Back-to-back class changes after an undefined/rotate op.
        vecs.push_back('{1'b0, 16'd3, 16'd4, 4'b0000, 16'd7, FL_ARITH, "b2b_add"});

        foreach (vecs[i]) step(vecs[i]);

        // Mid-stream reset: the pending MUL result is discarded, the next op lands.
        step('{1'b0, 16'd20, 16'd3, 4'b0010, 16'd60,   FL_ARITH, "pre_rst_mul"});
        step('{1'b1, 16'd20, 16'd3, 4'b0010, 16'h0000, FL_NONE,  "mid_rst_clear"});
        step('{1'b0, 16'h0015, 16'h000A, 4'b0101, 16'h001F, FL_LOGIC, "post_mid_rst_or"});
        step('{1'b1, 16'h0013, 16'h0000, 4'b1110, 16'h0000, FL_NONE,  "rst_over_shift"});
        step('{1'b0, 16'h0013, 16'h0000, 4'b1110, 16'h0026, FL_SHIFT, "post_rst_shl"});

        // Random back-to-back ADD/SUB/XOR against a bench-side reference.
        for (int i = 0; i < 24; i++) begin
            vec_t v;
            v.rst = 1'b0;
            v.a   = 16'($urandom);
            v.b   = 16'($urandom);
            case (i % 3)
                0: begin v.fun = 4'b0000; v.out = 16'((32'(v.a) + 32'(v.b)) % 32'h10000); end
                1: begin v.fun = 4'b0001; v.out = 16'((32'h10000 + 32'(v.a) - 32'(v.b)) % 32'h10000); end
                default: begin v.fun = 4'b1000; v.out = v.a ^ v.b; end
            endcase
            v.flg  = (v.fun == 4'b1000) ? FL_LOGIC : FL_ARITH;
            v.name = "rand_b2b";
            step(v);
        end

        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu16_registered.md
Name: alu16_registered

Overview:
- 16-bit, 16-function ALU with registered result and one-hot function-class flags.
- Covers unsigned arithmetic, bitwise logic, compare and shift on operands A and B, selected by a 4-bit opcode.
- Single clock domain; intended as a datapath execution unit behind a register file or controller.

Parameters:
- WIDTH, 16, operand and result width. Opcode width is fixed at 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- ALU_FUN  input  4  function select
- ALU_OUT  output  WIDTH  registered result
- Arith_Flag  output  1  registered; 1 when the captured opcode is arithmetic
- Logic_Flag  output  1  registered; 1 when the captured opcode is logic
- CMP_Flag  output  1  registered; 1 when the captured opcode is compare
- Shift_Flag  output  1  registered; 1 when the captured opcode is shift

Behaviour:
- Reset: synchronous, active-high, on the rising clk edge.
  - ALU_OUT = 0 and all four flags = 0.
  - Reset has priority over computation.
  - Asserting rst mid-stream discards the pending result; the first valid result appears 1 cycle after rst deasserts.
- Latency: combinational compute from A, B and ALU_FUN, captured on every rising clk edge.
  - Result for the inputs present at edge N is visible after edge N, i.e. 1 cycle of latency.
  - No handshake. A new operation is accepted every cycle.
- Opcode map (all unsigned; results truncated to WIDTH):
  - 0000 ADD: A+B; carry discarded (wrap mod 2^16).
  - 0001 SUB: A-B; wraps mod 2^16 (e.g. 5-10 = 0xFFFB).
  - 0010 MUL: lower 16 bits of A*B.
  - 0011 DIV: floor(A/B). If B = 0, result = 0.
  - 0100 AND: A&B
  - 0101 OR: A|B
  - 0110 NAND: ~(A&B)
  - 0111 NOR: ~(A|B)
  - 1000 XOR: A^B
  - 1001 XNOR: ~(A^B)
  - 1010 EQ: 1 if A==B, else 0.
  - 1011 GT: 2 if A>B, else 0.
  - 1100 LT: 3 if A<B, else 0.
  - 1101 SHR: A>>1, zero-fill at MSB; B ignored.
  - 1110 SHL: A<<1, MSB dropped, zero-fill at LSB; B ignored.
  - 1111: see Optional Feature.
- Flags: exactly one flag is high per cycle for a defined class, otherwise all are 0.
  - Arith_Flag for 0000–0011.
  - Logic_Flag for 0100–1001.
  - CMP_Flag for 1010–1100. The flag is high even when the comparison result is 0.
  - Shift_Flag for 1101–1110.
- Flags are registered in the same cycle as ALU_OUT; they never lead or lag the result.
- No internal state besides the output registers; back-to-back opcode changes are independent.

Optional Feature:
- Macro: ALU_ROTATE_EN.
- Defined: opcode 1111 = rotate A left by 1, {A[14:0],A[15]}, with Shift_Flag = 1.
- Undefined: opcode 1111 gives ALU_OUT = 0 and all flags = 0.

Test Plan:
- Reset: hold rst=1 for 2 edges with A=15, B=10, ALU_FUN=0000 -> ALU_OUT=0, flags=0000. Deassert -> after 1 edge, ALU_OUT=25, Arith_Flag=1.
- Arithmetic, A=15, B=10, one edge per opcode, Arith_Flag=1 each:
  - ADD=25, SUB=5, MUL=150, DIV=1.
  - Also DIV with B=0 -> 0.
  - Also SUB with A=5, B=10 -> 0xFFFB.
- Logic, A=0x15, B=0x0A, Logic_Flag=1 each:
  - AND=0x0000, OR=0x001F, NAND=0xFFFF, XOR=0x001F.
  - A=0x5, B=0xA: NOR=0xFFF0, XNOR=0xFFF0.
- Compare, CMP_Flag=1 each:
  - A=B=0x15, EQ -> 1.
  - A=0x1D, B=0x15, GT -> 2.
  - A=0x15, B=0x1D, LT -> 3.
  - A=0x15, B=0x1D, GT -> 0 with CMP_Flag still 1.
- Shift, Shift_Flag=1 each:
  - A=0x13: SHR -> 0x09, SHL -> 0x26.
  - A=0x8001: SHL -> 0x0002.
- Opcode 1111 with A=0x8001:
  - With ALU_ROTATE_EN -> 0x0003, Shift_Flag=1.
  - Without it -> 0x0000, flags=0000.
  - Also: rst asserted mid-sequence clears output on the next edge.
